// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
//   Raster timing generator for the VGA output path. Divides the system clock
//   to a pixel rate, runs horizontal/vertical position counters and produces
//   registered sync, visible-area, coordinate and linear-index outputs for
//   the downstream pixel generator.
//
// Ports
//   clk           in   system clock
//   rst           in   asynchronous active-high reset
//   pixel_tick    out  pixel-rate enable, one clk in every CLK_DIV
//   hsync         out  horizontal sync (SYNC_ACTIVE inside the sync window)
//   vsync         out  vertical sync   (SYNC_ACTIVE inside the sync window)
//   visible_area  out  position is inside the visible window
//   pixel_x       out  column while visible, else 0
//   pixel_y       out  line while visible, else 0
//   id            out  linear framebuffer index y*H_VISIBLE+x while visible
//   frame_start   out  one-clk pulse when the position enters (0,0)
// ---------------------------------------------------------------------------
module vga_timing #(
    parameter int CLK_DIV     = 2,
    parameter int H_VISIBLE   = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        pixel_tick,
    output logic        hsync,
    output logic        vsync,
    output logic        visible_area,
    output logic [9:0]  pixel_x,
    output logic [8:0]  pixel_y,
    output logic [18:0] id,
    output logic        frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // A one-bit counter is kept even for CLK_DIV=1; it simply stays at 0,
    // which makes the decoded tick permanently high.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [DIV_W-1:0] r_div_cnt;
    logic [9:0]       r_h_cnt;
    logic [9:0]       r_v_cnt;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_visible;
    logic [9:0]       r_pixel_x;
    logic [8:0]       r_pixel_y;
    logic [18:0]      r_id;
    logic             r_frame_start;

    logic             w_tick;
    logic [9:0]       w_h_next;
    logic [9:0]       w_v_next;
    logic             w_origin;
    logic             w_visible;

    // Tick is decoded straight from the divider register, so it is
    // glitch-free and aligned with the edge that advances the position.
    assign w_tick = (r_div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // Next raster position; the outputs below are all registered from it so
    // they line up with the counters after the advancing edge.
    always_comb begin
        w_h_next = r_h_cnt + 10'd1;
        w_v_next = r_v_cnt;
        if (r_h_cnt == H_LAST) begin
            w_h_next = '0;
            w_v_next = (r_v_cnt == V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
        end
    end

    assign w_origin  = (w_h_next == 10'd0) && (w_v_next == 10'd0);
    assign w_visible = (w_h_next < H_VIS) && (w_v_next < V_VIS);

    // Counters reset to the last position of the frame so the very first
    // advance after reset lands on (0,0) and raises frame_start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt       <= H_LAST;
            r_v_cnt       <= V_LAST;
            r_hsync       <= ~SYNC_ACTIVE;
            r_vsync       <= ~SYNC_ACTIVE;
            r_visible     <= 1'b0;
            r_pixel_x     <= '0;
            r_pixel_y     <= '0;
            r_id          <= '0;
            r_frame_start <= 1'b0;
        end else if (w_tick) begin
            r_h_cnt       <= w_h_next;
            r_v_cnt       <= w_v_next;
            r_hsync       <= ((w_h_next >= HS_BEG) && (w_h_next < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_vsync       <= ((w_v_next >= VS_BEG) && (w_v_next < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_visible     <= w_visible;
            r_pixel_x     <= w_visible ? w_h_next : 10'd0;
            r_pixel_y     <= w_visible ? w_v_next[8:0] : 9'd0;
            r_frame_start <= w_origin;
            // Visible pixels are scanned in raster order, so the linear index
            // is a running count: restart at the origin, step on every
            // visible pixel and hold across blanking.
            if (w_origin) begin
                r_id <= '0;
            end else if (w_visible) begin
                r_id <= r_id + 19'd1;
            end
        end else begin
            r_frame_start <= 1'b0;
        end
    end

    assign pixel_tick   = w_tick;
    assign hsync        = r_hsync;
    assign vsync        = r_vsync;
    assign visible_area = r_visible;
    assign pixel_x      = r_pixel_x;
    assign pixel_y      = r_pixel_y;
    assign id           = r_id;
    assign frame_start  = r_frame_start;

endmodule

// File: tb/tb_vga_timing.sv
// ---------------------------------------------------------------------------
// tb_vga_timing
//   Two reduced-geometry instances (CLK_DIV=2/active-low sync and
//   CLK_DIV=1/active-high sync) share clock and a randomly pulsed reset.
//   A model process pushes expected outputs per clk from the elapsed edge
//   count; a monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_vga_timing;

    // instance A geometry: 15 x 10 total, 8 x 6 visible
    localparam int A_D = 2, A_HV = 8, A_HF = 2, A_HS = 3, A_HB = 2;
    localparam int A_VV = 6, A_VF = 1, A_VS = 2, A_VB = 1;
    localparam bit A_SA = 1'b0;
    // instance B geometry: 9 x 8 total, 5 x 4 visible
    localparam int B_D = 1, B_HV = 5, B_HF = 1, B_HS = 2, B_HB = 1;
    localparam int B_VV = 4, B_VF = 1, B_VS = 1, B_VB = 2;
    localparam bit B_SA = 1'b1;

    typedef struct {
        logic tick, hs, vs, vis, fs;
        int   px, py, id;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        a_tick, a_hs, a_vs, a_vis, a_fs;
    logic [9:0]  a_px;
    logic [8:0]  a_py;
    logic [18:0] a_id;
    logic        b_tick, b_hs, b_vs, b_vis, b_fs;
    logic [9:0]  b_px;
    logic [8:0]  b_py;
    logic [18:0] b_id;

    int checks   = 0;
    int failures = 0;
    int edges    = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    vga_timing #(
        .CLK_DIV(A_D), .H_VISIBLE(A_HV), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
        .V_VISIBLE(A_VV), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB), .SYNC_ACTIVE(A_SA)
    ) u_a (
        .clk(clk), .rst(rst), .pixel_tick(a_tick), .hsync(a_hs), .vsync(a_vs),
        .visible_area(a_vis), .pixel_x(a_px), .pixel_y(a_py), .id(a_id),
        .frame_start(a_fs)
    );

    vga_timing #(
        .CLK_DIV(B_D), .H_VISIBLE(B_HV), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_VISIBLE(B_VV), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB), .SYNC_ACTIVE(B_SA)
    ) u_b (
        .clk(clk), .rst(rst), .pixel_tick(b_tick), .hsync(b_hs), .vsync(b_vs),
        .visible_area(b_vis), .pixel_x(b_px), .pixel_y(b_py), .id(b_id),
        .frame_start(b_fs)
    );

    // Expected outputs after e clock edges since reset release (e=0: in reset).
    // Tick number n = e/D has been consumed; tick k lands on raster position
    // k-1 counted from (0,0), so the position is pure arithmetic on n.
    function automatic exp_t model(int e, int d, int hv, int hf, int hs, int hb,
                                   int vv, int vf, int vs, int vb, bit sa);
        exp_t r;
        int ht, vt, n, p, x, y;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        r.tick = ((e % d) == d - 1);
        n = e / d;
        r.hs = ~sa; r.vs = ~sa; r.vis = 1'b0; r.fs = 1'b0;
        r.px = 0; r.py = 0; r.id = 0;
        if (n > 0) begin
            p = (n - 1) % (ht * vt);
            x = p % ht;
            y = p / ht;
            r.vis = (x < hv) && (y < vv);
            r.hs  = (x >= hv + hf && x < hv + hf + hs) ? sa : ~sa;
            r.vs  = (y >= vv + vf && y < vv + vf + vs) ? sa : ~sa;
            r.px  = r.vis ? x : 0;
            r.py  = r.vis ? y : 0;
            if (r.vis)        r.id = y * hv + x;
            else if (y < vv)  r.id = y * hv + hv - 1;   // last pixel of this line
            else              r.id = vv * hv - 1;       // last pixel of the frame
            r.fs  = ((e % d) == 0) && (p == 0);
        end
        return r;
    endfunction

    task automatic chk(string nm, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, req);
        end
    endtask

    task automatic cmp(string dn, exp_t x, logic tk, logic hs, logic vs, logic vis,
                       logic fs, logic [9:0] px, logic [8:0] py, logic [18:0] idv);
        chk({dn, ".pixel_tick"},   int'(tk),  int'(x.tick));
        chk({dn, ".hsync"},        int'(hs),  int'(x.hs));
        chk({dn, ".vsync"},        int'(vs),  int'(x.vs));
        chk({dn, ".visible_area"}, int'(vis), int'(x.vis));
        chk({dn, ".frame_start"},  int'(fs),  int'(x.fs));
        chk({dn, ".pixel_x"},      int'(px),  x.px);
        chk({dn, ".pixel_y"},      int'(py),  x.py);
        chk({dn, ".id"},           int'(idv), x.id);
    endtask

    // Model side: one expected record per clock edge for each instance.
    always @(posedge clk) begin
        if (rst) edges = 0;
        else     edges = edges + 1;
        qa.push_back(model(edges, A_D, A_HV, A_HF, A_HS, A_HB, A_VV, A_VF, A_VS, A_VB, A_SA));
        qb.push_back(model(edges, B_D, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB, B_SA));
    end

    // Monitor side: outputs are valid every clk; compare mid-cycle.
    always @(negedge clk) begin
        exp_t xa, xb;
        if (qa.size() == 0 || qb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty t=%0t actual=%0d required=1", $time, qa.size());
        end else begin
            xa = qa.pop_front();
            xb = qb.pop_front();
            cmp("A", xa, a_tick, a_hs, a_vs, a_vis, a_fs, a_px, a_py, a_id);
            cmp("B", xb, b_tick, b_hs, b_vs, b_vis, b_fs, b_px, b_py, b_id);
        end
    end

    initial begin
        int run;
        exp_t ra, rb;
        ra = model(0, A_D, A_HV, A_HF, A_HS, A_HB, A_VV, A_VF, A_VS, A_VB, A_SA);
        rb = model(0, B_D, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB, B_SA);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        for (int seg = 0; seg < 6; seg++) begin
            // first run covers several full frames of both instances
            run = (seg == 0) ? 700 : $urandom_range(40, 900);
            repeat (run) @(negedge clk);
            // mid-cycle assertion: outputs must drop without a clock edge
            #2 rst = 1'b1;
            #1 cmp("A_async", ra, a_tick, a_hs, a_vs, a_vis, a_fs, a_px, a_py, a_id);
            cmp("B_async", rb, b_tick, b_hs, b_vs, b_vis, b_fs, b_px, b_py, b_id);
            repeat ($urandom_range(1, 3)) @(negedge clk);
            #2 rst = 1'b0;
        end
        repeat (700) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
# vga_timing

Raster timing generator for the VGA output path, sitting directly upstream of the pixel generator. It divides the system clock down to a pixel rate and runs horizontal and vertical position counters. From these it produces hsync/vsync, the visible-area flag, pixel coordinates and a linear framebuffer index (`id`), all registered so the pixel generator sees glitch-free inputs. Defaults target 640x480 @ 60 Hz (800x525 total) from a 50 MHz clock.

## Interface
- `CLK_DIV`, 2: system clocks per pixel; must be ≥ 1. A value of 1 makes the tick permanently high.
- `H_VISIBLE`, 640: visible columns.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_VISIBLE`, 480: visible lines.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `SYNC_ACTIVE`, 0: level driven on hsync/vsync during their sync windows. The inactive level is `~SYNC_ACTIVE`.

Ports:
- `clk`  in  1  system clock (single clock domain).
- `rst`  in  1  reset, asynchronous, active-high.
- `pixel_tick`  out  1  pixel-rate enable, high one `clk` in every `CLK_DIV`.
- `hsync`  out  1  horizontal sync.
- `vsync`  out  1  vertical sync.
- `visible_area`  out  1  current position is inside the visible window.
- `pixel_x`  out  10  column while visible, else 0.
- `pixel_y`  out  9  line while visible, else 0.
- `id`  out  19  linear index, y*H_VISIBLE + x, while visible.
- `frame_start`  out  1  one-`clk` pulse when the position enters (0,0).

## Operation
- Derived values:
  - H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525).
- Divider: `div_cnt` counts 0..CLK_DIV-1 and wraps. `pixel_tick` = (`div_cnt` == CLK_DIV-1), decoded from the register.
- Position registers `h_cnt` (10 b, 0..H_TOTAL-1) and `v_cnt` (10 b, 0..V_TOTAL-1) advance only on edges where `pixel_tick` is high:
  - `h_cnt` increments.
  - At H_TOTAL-1, `h_cnt` wraps to 0 and `v_cnt` increments.
  - At (H_TOTAL-1, V_TOTAL-1) both wrap to 0.
- On that same edge, all other outputs are registered from the *new* position:
  - `visible_area` = h<H_VISIBLE && v<V_VISIBLE.
  - `hsync` = SYNC_ACTIVE when h ∈ [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1] (656..751); otherwise `~SYNC_ACTIVE`.
  - `vsync` = SYNC_ACTIVE when v ∈ [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1] (490..491); otherwise `~SYNC_ACTIVE`.
  - `pixel_x`/`pixel_y` = h / v[8:0] when visible, else 0.
  - `id`: 0 when the new position is (0,0).
  - `id`: previous `id`+1 when the new position is visible and not (0,0).
  - `id`: holds its value during blanking.
  - `id` is generated without a multiplier. Maximum value is 307199.
  - `frame_start` = 1 when the new position is (0,0), else 0.
- On edges without a tick:
  - `frame_start` is cleared.
  - All other outputs hold.

## Timing
- Reset (async assert, synchronous release):
  - `div_cnt`=0.
  - `h_cnt`=H_TOTAL-1, `v_cnt`=V_TOTAL-1.
  - `hsync`=`vsync`=~SYNC_ACTIVE.
  - `visible_area`=0, `pixel_x`=0, `pixel_y`=0, `id`=0.
  - `frame_start`=0.
  - `pixel_tick`=0, or 1 when CLK_DIV=1.
- First tick after reset:
  - `pixel_tick` goes high after the (CLK_DIV-1)th rising edge.
  - On the CLK_DIV-th edge the position wraps to (0,0), `visible_area`=1, `id`=0 and `frame_start`=1 for one `clk`.
- Outputs change only on tick edges, so each value is stable for CLK_DIV clocks. The exception is `frame_start`, which is high for exactly one `clk`.
- Reset asserted mid-frame: all outputs go to their reset values immediately. The first frame after release is a full frame starting at (0,0).
- Line period is H_TOTAL ticks; frame period is H_TOTAL*V_TOTAL ticks (420000).

## Test plan
- Reset release with CLK_DIV=2:
  - `pixel_tick` toggles 0,1,0,1.
  - After edge 2: `frame_start`=1 for one clk, `visible_area`=1, `pixel_x`=0, `pixel_y`=0, `id`=0.
- One line:
  - `visible_area` is high for exactly 640 ticks, then low for 160.
  - `hsync` is low from tick 656 through 751 (96 ticks); no other `hsync` transitions.
- Index continuity:
  - At (639,0), `id`=639.
  - At (0,1), `id`=640.
  - At (639,479), `id`=307199.
  - `id` holds 307199 through vertical blanking and returns to 0 with `frame_start`.
- Vertical:
  - `vsync` is low exactly while `v_cnt` = 490..491 (1600 ticks).
  - `frame_start` period is 420000 ticks (840000 clk at CLK_DIV=2).
- Reset at (100,200) mid-frame:
  - Outputs go to reset values asynchronously, without waiting for `clk`.
  - After release, the next advance lands on (0,0) with `frame_start`=1.
- CLK_DIV=1, SYNC_ACTIVE=1:
  - `pixel_tick` is constant 1.
  - `hsync` is high for 96 consecutive clks per 800.
